// File: rtl/mmio_sorter_pkg.sv
// Shared definitions for the memory-mapped sort accelerator: FSM states,
// register offsets within the block's address window, and register bit indices.
package mmio_sorter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Word offsets within the block's 28-bit offset space (addr_i[27:0]).
  localparam logic [27:0] CTRL_OFF   = 28'h0;
  localparam logic [27:0] STATUS_OFF = 28'h1;
  localparam logic [27:0] DATA_OFF   = 28'h10;

  // CTRL bits.
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DESC_BIT  = 1;

  // STATUS bits (read side: busy/done/err; write side: done/err are clear strobes).
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

endpackage

// File: rtl/mmio_sorter_cmp_swap.sv
// Combinational compare-exchange for one adjacent element pair.
// lo_o is the value that belongs at the lower index after the exchange,
// hi_o the value for the higher index. Equal inputs are passed straight through.
module cmp_swap
  import mmio_sorter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              desc,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o
);

  logic a_gt_b;
  logic a_lt_b;
  logic swap;

  generate
    if (SIGNED) begin : g_signed
      assign a_gt_b = $signed(a) > $signed(b);
      assign a_lt_b = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign a_gt_b = a > b;
      assign a_lt_b = a < b;
    end
  endgenerate

  // Swap only on a strict ordering violation so equal elements never move.
  always_comb begin
    swap = desc ? a_lt_b : a_gt_b;
    lo_o = swap ? b : a;
    hi_o = swap ? a : b;
  end

endmodule

// File: rtl/mmio_sorter.sv
// Memory-mapped odd-even transposition sorter. Software loads NUM_ELEM
// elements, writes CTRL.start, polls STATUS and reads the result in place.
// Bus semantics: wr_en_i is a single-cycle write strobe taken at the rising
// edge; every cycle the presented addr_i is decoded and data_o returns, one
// cycle later, the read value computed from pre-edge state. There is no
// back-pressure: writes that cannot be honoured are dropped and flag err.
module mmio_sorter
  import mmio_sorter_pkg::*;
#(
  parameter int          NUM_ELEM = 4,
  parameter int          DATA_W   = 32,
  parameter bit          SIGNED   = 1'b0,
  parameter logic [3:0]  BASE     = 4'h1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [7:0] LAST_PASS = 8'(NUM_ELEM - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] elem_q [NUM_ELEM];
  logic [DATA_W-1:0] elem_d [NUM_ELEM];
  logic [7:0]        pass_cnt_q, pass_cnt_d;
  logic              desc_q, desc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  // Pair outputs; slot NUM_ELEM-1 has no pair and is tied off.
  logic [DATA_W-1:0] lo_w [NUM_ELEM];
  logic [DATA_W-1:0] hi_w [NUM_ELEM];

  logic                sel;
  logic [27:0]         off;
  logic                ctrl_hit;
  logic                status_hit;
  logic [NUM_ELEM-1:0] data_hit;
  logic                busy;
  logic                wr_start;
  logic                wr_data;

  function automatic logic [31:0] extend(input logic [DATA_W-1:0] v);
    logic [31:0] r;
    r = (SIGNED && v[DATA_W-1]) ? '1 : '0;
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  assign sel  = (addr_i[31:28] == BASE);
  assign off  = addr_i[27:0];
  assign busy = (state_q == ST_SORT);

  // Address decode for the block's own window.
  always_comb begin
    ctrl_hit   = sel && (off == CTRL_OFF);
    status_hit = sel && (off == STATUS_OFF);
    data_hit   = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      data_hit[i] = sel && (off == (DATA_OFF + 28'(i)));
    end
    wr_start = wr_en_i && ctrl_hit && data_i[CTRL_START_BIT];
    wr_data  = wr_en_i && (|data_hit);
  end

  generate
    for (genvar k = 0; k < NUM_ELEM - 1; k++) begin : g_pair
      cmp_swap #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
      ) u_cmp_swap (
        .a    (elem_q[k]),
        .b    (elem_q[k+1]),
        .desc (desc_q),
        .lo_o (lo_w[k]),
        .hi_o (hi_w[k])
      );
    end
  endgenerate

  assign lo_w[NUM_ELEM-1] = '0;
  assign hi_w[NUM_ELEM-1] = '0;

  // Next-state: FSM, element array, pass counter and sticky flags.
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    pass_cnt_d = pass_cnt_q;
    desc_d     = desc_q;
    done_d     = done_q;
    err_d      = err_q;

    // Clear strobes first so that a completion on the same edge wins.
    if (wr_en_i && status_hit && data_i[STAT_DONE_BIT]) done_d = 1'b0;

    case (state_q)
      ST_SORT: begin
        // Pass parity picks the even pairs (0,1),(2,3).. or odd pairs (1,2),(3,4)..
        for (int k = 0; k < NUM_ELEM - 1; k++) begin
          if (k[0] == pass_cnt_q[0]) begin
            elem_d[k]   = lo_w[k];
            elem_d[k+1] = hi_w[k];
          end
        end
        pass_cnt_d = pass_cnt_q + 8'd1;
        if (wr_data || wr_start) err_d = 1'b1;
        if (pass_cnt_q == LAST_PASS) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE accept loads and starts alike.
        if (wr_en_i) begin
          for (int i = 0; i < NUM_ELEM; i++) begin
            if (data_hit[i]) elem_d[i] = data_i[DATA_W-1:0];
          end
        end
        if (wr_start) begin
          desc_d     = data_i[CTRL_DESC_BIT];
          pass_cnt_d = 8'd0;
          if (NUM_ELEM == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SORT;
            done_d  = 1'b0;
          end
        end
      end
    endcase

    if (wr_en_i && status_hit && data_i[STAT_ERR_BIT]) err_d = 1'b0;
  end

  // Read mux from pre-edge state; registered into data_o.
  always_comb begin
    rdata_d = '0;
    if (ctrl_hit) begin
      rdata_d = {30'd0, desc_q, 1'b0};
    end else if (status_hit) begin
      rdata_d = {16'd0, pass_cnt_q, 5'd0, err_q, done_q, busy};
    end else begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (data_hit[i]) rdata_d = extend(elem_q[i]);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < NUM_ELEM; i++) elem_q[i] <= '0;
      pass_cnt_q <= 8'd0;
      desc_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      pass_cnt_q <= pass_cnt_d;
      desc_q     <= desc_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign data_o = rdata_q;
  assign busy_o = busy;
  assign done_o = done_q;

endmodule

// File: tb/tb_mmio_sorter.sv
// Bench for mmio_sorter: three instances (default, signed 5x8, single element)
// share one register bus and are told apart by their base nibble.
module tb_mmio_sorter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] dout0, dout1, dout2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  mmio_sorter #(.NUM_ELEM(4), .DATA_W(32), .SIGNED(1'b0), .BASE(4'h1)) u_def (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .addr_i(addr), .data_i(wdata),
    .data_o(dout0), .busy_o(busy0), .done_o(done0));

  mmio_sorter #(.NUM_ELEM(5), .DATA_W(8), .SIGNED(1'b1), .BASE(4'h2)) u_sgn (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .addr_i(addr), .data_i(wdata),
    .data_o(dout1), .busy_o(busy1), .done_o(done1));

  mmio_sorter #(.NUM_ELEM(1), .DATA_W(32), .SIGNED(1'b0), .BASE(4'h3)) u_one (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .addr_i(addr), .data_i(wdata),
    .data_o(dout2), .busy_o(busy2), .done_o(done2));

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
  endtask

  function automatic logic [31:0] dut_dout(input int d);
    case (d)
      0: return dout0;
      1: return dout1;
      default: return dout2;
    endcase
  endfunction

  function automatic logic dut_busy(input int d);
    case (d)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic dut_done(input int d);
    case (d)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Per instance: register file contents, remaining sort cycles, and the
  // fully sorted result that becomes visible when the countdown expires.
  int          m_n   [3] = '{4, 5, 1};
  int          m_w   [3] = '{32, 8, 32};
  bit          m_sg  [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0]  m_base[3] = '{4'h1, 4'h2, 4'h3};
  logic [31:0] m_el  [3][64];
  logic [31:0] m_res [3][64];
  int          m_left[3];
  int          m_pass[3];
  bit          m_desc[3];
  bit          m_done[3];
  bit          m_err [3];
  logic [31:0] exp_dout  [3];
  bit          exp_dvalid[3];

  function automatic logic [31:0] mask_of(input int d);
    logic [63:0] m;
    m = (64'd1 << m_w[d]) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic [31:0] ext(input int d, input logic [31:0] v);
    logic [31:0] r;
    r = v & mask_of(d);
    if (m_sg[d] && r[m_w[d]-1]) r = r | ~mask_of(d);
    return r;
  endfunction

  function automatic longint key(input int d, input logic [31:0] v);
    logic [31:0] e;
    e = ext(d, v);
    if (m_sg[d]) return longint'($signed(e));
    return longint'({32'd0, e});
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a, output bit valid);
    int off;
    valid = 1'b1;
    if (a[31:28] != m_base[d]) return 32'd0;
    off = int'(a[27:0]);
    if (off == 0) return {30'd0, m_desc[d], 1'b0};
    if (off == 1) return {16'd0, 8'(m_pass[d]), 5'd0, m_err[d], m_done[d], (m_left[d] > 0)};
    if (off >= 16 && off < 16 + m_n[d]) begin
      // Mid-sort contents are intermediate; only settled contents are predicted.
      valid = !(m_left[d] > 0);
      return ext(d, m_el[d][off-16]);
    end
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 64; i++) begin
        m_el[d][i]  = '0;
        m_res[d][i] = '0;
      end
      m_left[d] = 0; m_pass[d] = 0; m_desc[d] = 0; m_done[d] = 0; m_err[d] = 0;
      exp_dout[d] = '0; exp_dvalid[d] = 1'b1;
    end
  endtask

  task automatic model_start(input int d, input bit desc);
    logic [31:0] t;
    m_desc[d] = desc;
    m_pass[d] = 0;
    if (m_n[d] == 1) begin
      m_done[d] = 1'b1;
    end else begin
      m_done[d] = 1'b0;
      m_left[d] = m_n[d];
      for (int i = 0; i < m_n[d]; i++) m_res[d][i] = m_el[d][i];
      for (int p = 0; p < m_n[d]; p++) begin
        for (int j = 0; j < m_n[d] - 1; j++) begin
          if (desc ? (key(d, m_res[d][j]) < key(d, m_res[d][j+1]))
                   : (key(d, m_res[d][j]) > key(d, m_res[d][j+1]))) begin
            t = m_res[d][j]; m_res[d][j] = m_res[d][j+1]; m_res[d][j+1] = t;
          end
        end
      end
    end
  endtask

  task automatic model_step(input int d);
    bit busy_pre, fin, v;
    int off;
    busy_pre = (m_left[d] > 0);
    fin = 1'b0;
    exp_dout[d] = model_read(d, addr, v);
    exp_dvalid[d] = v;
    if (busy_pre) begin
      m_pass[d]++;
      m_left[d]--;
      if (m_left[d] == 0) fin = 1'b1;
    end
    if (wr_en && addr[31:28] == m_base[d]) begin
      off = int'(addr[27:0]);
      if (off == 0) begin
        if (wdata[0]) begin
          if (busy_pre) m_err[d] = 1'b1;
          else model_start(d, wdata[1]);
        end
      end else if (off == 1) begin
        if (wdata[1]) m_done[d] = 1'b0;
        if (wdata[2]) m_err[d] = 1'b0;
      end else if (off >= 16 && off < 16 + m_n[d]) begin
        if (busy_pre) m_err[d] = 1'b1;
        else m_el[d][off-16] = wdata & mask_of(d);
      end
    end
    if (fin) begin
      for (int i = 0; i < m_n[d]; i++) m_el[d][i] = m_res[d][i];
      m_done[d] = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int d = 0; d < 3; d++) model_step(d);
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int d = 0; d < 3; d++) begin
          chk_b($sformatf("cycle dut%0d busy_o", d), dut_busy(d), (m_left[d] > 0));
          chk_b($sformatf("cycle dut%0d done_o", d), dut_done(d), m_done[d]);
          if (exp_dvalid[d]) chk($sformatf("cycle dut%0d data_o", d), dut_dout(d), exp_dout[d]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic rd(input string name, input int d, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    @(negedge clk);
    chk(name, dut_dout(d), exp);
    addr = 32'h0;
  endtask

  task automatic load4(input logic [31:0] v0, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] v3);
    wr(32'h1000_0010, v0);
    wr(32'h1000_0011, v1);
    wr(32'h1000_0012, v2);
    wr(32'h1000_0013, v3);
  endtask

  task automatic read4(input string name, input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    rd({name, " [0]"}, 0, 32'h1000_0010, e0);
    rd({name, " [1]"}, 0, 32'h1000_0011, e1);
    rd({name, " [2]"}, 0, 32'h1000_0012, e2);
    rd({name, " [3]"}, 0, 32'h1000_0013, e3);
  endtask

  // Counts sampled cycles with busy_o high, bounded so a stuck FSM still ends.
  task automatic wait_idle(input string name, input int d, input int exp_cycles);
    int c;
    c = 0;
    while (dut_busy(d) && c < 50) begin
      c++;
      @(negedge clk);
    end
    chk(name, 32'(c), 32'(exp_cycles));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; wr_en = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    rst_n  = 1'b1;

    // Reset state
    chk_b("reset busy_o", busy0, 1'b0);
    chk_b("reset done_o", done0, 1'b0);
    chk("reset data_o", dout0, 32'h0);
    rd("reset STATUS", 0, 32'h1000_0001, 32'h0);
    rd("reset DATA0", 0, 32'h1000_0010, 32'h0);

    // Ascending
    load4(7, 3, 9, 1);
    wr(32'h1000_0000, 32'h1);
    wait_idle("asc busy cycles", 0, 4);
    chk_b("asc done_o", done0, 1'b1);
    read4("asc", 1, 3, 7, 9);
    rd("asc STATUS", 0, 32'h1000_0001, 32'h0000_0402);
    rd("asc CTRL", 0, 32'h1000_0000, 32'h0);

    // Descending
    load4(7, 3, 9, 1);
    wr(32'h1000_0000, 32'h3);
    wait_idle("desc busy cycles", 0, 4);
    read4("desc", 9, 7, 3, 1);
    rd("desc CTRL", 0, 32'h1000_0000, 32'h2);

    // Duplicates
    load4(5, 5, 2, 5);
    wr(32'h1000_0000, 32'h1);
    wait_idle("dup busy cycles", 0, 4);
    read4("dup", 2, 5, 5, 5);

    // Signed 5 x 8-bit; upper write bits beyond DATA_W are dropped
    wr(32'h2000_0010, 32'h80);
    wr(32'h2000_0011, 32'h7F);
    wr(32'h2000_0012, 32'h00);
    wr(32'h2000_0013, 32'hFF);
    wr(32'h2000_0014, 32'h1234_5601);
    wr(32'h2000_0000, 32'h1);
    wait_idle("signed busy cycles", 1, 5);
    rd("signed [0]", 1, 32'h2000_0010, 32'hFFFF_FF80);
    rd("signed [1]", 1, 32'h2000_0011, 32'hFFFF_FFFF);
    rd("signed [2]", 1, 32'h2000_0012, 32'h0000_0000);
    rd("signed [3]", 1, 32'h2000_0013, 32'h0000_0001);
    rd("signed [4]", 1, 32'h2000_0014, 32'h0000_007F);
    rd("signed STATUS", 1, 32'h2000_0001, 32'h0000_0502);

    // Single element: start completes on the capturing edge
    wr(32'h3000_0010, 32'h55);
    wr(32'h3000_0000, 32'h1);
    chk_b("n1 done_o", done2, 1'b1);
    chk_b("n1 busy_o", busy2, 1'b0);
    rd("n1 DATA0", 2, 32'h3000_0010, 32'h55);
    rd("n1 STATUS", 2, 32'h3000_0001, 32'h0000_0002);
    rd("n1 past end", 2, 32'h3000_0011, 32'h0);

    // Out-of-range offset and base mismatch
    rd("past end", 0, 32'h1000_0014, 32'h0);
    rd("wrong base", 0, 32'h5000_0010, 32'h0);

    // Writes while busy
    load4(7, 3, 9, 1);
    wr(32'h1000_0000, 32'h1);
    wr(32'h1000_0010, 32'hAA);
    wr(32'h1000_0000, 32'h1);
    wait_idle("busy-write remaining cycles", 0, 2);
    read4("busy-write", 1, 3, 7, 9);
    rd("busy-write STATUS", 0, 32'h1000_0001, 32'h0000_0406);
    wr(32'h1000_0001, 32'h4);
    rd("err clear STATUS", 0, 32'h1000_0001, 32'h0000_0402);
    wr(32'h1000_0001, 32'h2);
    rd("done clear STATUS", 0, 32'h1000_0001, 32'h0000_0400);

    // Done-clear on the completing edge: completion wins
    load4(4, 2, 8, 6);
    wr(32'h1000_0000, 32'h1);
    repeat (3) @(negedge clk);
    wr(32'h1000_0001, 32'h2);
    chk_b("done-clear race done_o", done0, 1'b1);
    chk_b("done-clear race busy_o", busy0, 1'b0);
    read4("race", 2, 4, 6, 8);

    // Reset mid-sort (descending so desc is set when reset hits)
    load4(7, 3, 9, 1);
    wr(32'h1000_0000, 32'h3);
    addr = 32'h1000_0001;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_b("async reset busy_o", busy0, 1'b0);
    chk_b("async reset done_o", done0, 1'b0);
    chk("async reset data_o", dout0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 32'h0;
    read4("post-reset", 0, 0, 0, 0);
    rd("post-reset CTRL", 0, 32'h1000_0000, 32'h0);
    rd("post-reset STATUS", 0, 32'h1000_0001, 32'h0);

    repeat (2) @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound in case a wait construct above is ever broken.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
